// File: rtl/ifq_pkg.sv
// Shared widths and helpers for the instruction fetch queue.
// Defaults match the standard 4-word line, 4-slot configuration.
package ifq_pkg;
    localparam int XLEN      = 32;
    localparam int WORDS_DEF = 4;
    localparam int DEPTH_DEF = 4;
    localparam int OFF_W     = $clog2(WORDS_DEF);
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int CNT_W     = PTR_W + 1;

    // Clear the low lsb bits of a byte address.
    function automatic logic [XLEN-1:0] align_down(input logic [XLEN-1:0] a, input int lsb);
        return a & ~((XLEN'(1) << lsb) - XLEN'(1));
    endfunction
endpackage

// File: rtl/ifq_line_ram.sv
// Line storage for the fetch queue: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module ifq_line_ram #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [LINE_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [LINE_W-1:0]        rdata
);
    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ifq_param.sv
// Instruction fetch queue: buffers whole cache lines and hands decode one
// 32-bit word per Rd_en; a branch redirect flushes and refetches from target.
module ifq_param
    import ifq_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [32*WORDS-1:0]      Dout,
    input  logic                     Dout_valid,
    input  logic                     Rd_en,
    input  logic [31:0]              Jmp_branch_address,
    input  logic                     Jmp_branch_valid,
    output logic [31:0]              Pc_in,
    output logic                     Rd_en_cache,
    output logic [31:0]              Pc_out,
    output logic [31:0]              Inst,
    output logic                     Empty,
    output logic                     Full,
    output logic [$clog2(DEPTH):0]   Line_cnt
);
    localparam int OW = $clog2(WORDS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         wp, rp;
    logic [OW-1:0]         rw;
    logic [CW-1:0]         cnt;
    logic [32*WORDS-1:0]   head_line;
    logic                  wr, rd, retire;

    assign Empty       = (cnt == '0);
    assign Full        = (cnt == CW'(DEPTH));
    assign Rd_en_cache = !Full;
    assign Line_cnt    = cnt;

    // Redirect wins over both queue operations in the same cycle.
    assign wr     = Dout_valid && !Full && !Jmp_branch_valid;
    assign rd     = Rd_en && !Empty && !Jmp_branch_valid;
    assign retire = rd && (rw == OW'(WORDS - 1));

    assign Inst = head_line[{rw, 5'b0} +: 32];

    ifq_line_ram #(
        .DEPTH  (DEPTH),
        .LINE_W (32 * WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (wr),
        .waddr (wp),
        .wdata (Dout),
        .raddr (rp),
        .rdata (head_line)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            Pc_in  <= '0;
            Pc_out <= '0;
            wp     <= '0;
            rp     <= '0;
            rw     <= '0;
            cnt    <= '0;
        end else if (Jmp_branch_valid) begin
            // Start mid-line at the target word; the fetch address is line aligned.
            Pc_in  <= align_down(Jmp_branch_address, OW + 2);
            Pc_out <= align_down(Jmp_branch_address, 2);
            rw     <= Jmp_branch_address[OW+1:2];
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
        end else begin
            if (wr) begin
                wp    <= wp + PW'(1);
                Pc_in <= Pc_in + XLEN'(4 * WORDS);
            end
            if (rd) begin
                Pc_out <= Pc_out + XLEN'(4);
                if (retire) begin
                    rw <= '0;
                    rp <= rp + PW'(1);
                end else begin
                    rw <= rw + OW'(1);
                end
            end
            case ({wr, retire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: doc/ifq_param.md
IFQ_PARAM -- requirements
Module: ifq_param

Interface
REQ-001 SHALL have parameter WORDS, default 4, meaning 32-bit instruction words per cache line (power of two, >=2).
REQ-002 SHALL have parameter DEPTH, default 4, meaning line slots in the queue (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Dout  input  32*WORDS  cache line returned for Pc_in; word i at bits [32i+31:32i].
REQ-006 SHALL have port Dout_valid  input  1  Dout is valid this cycle.
REQ-007 SHALL have port Rd_en  input  1  decode consumes Inst this cycle.
REQ-008 SHALL have port Jmp_branch_address  input  32  redirect target, byte address.
REQ-009 SHALL have port Jmp_branch_valid  input  1  redirect strobe.
REQ-010 SHALL have port Pc_in  output  32  line-aligned fetch address to the cache.
REQ-011 SHALL have port Rd_en_cache  output  1  fetch request; equals !Full.
REQ-012 SHALL have port Pc_out  output  32  byte address of Inst.
REQ-013 SHALL have port Inst  output  32  head instruction word.
REQ-014 SHALL have port Empty  output  1  no valid word at head.
REQ-015 SHALL have port Full  output  1  all DEPTH slots occupied.
REQ-016 SHALL have port Line_cnt  output  clog2(DEPTH)+1  occupied line slots.

Function
REQ-017 SHALL accept a line (write) when Dout_valid && !Full && !Jmp_branch_valid; Dout_valid otherwise ignored.
REQ-018 On write: slot[wp] <= Dout, wp <= (wp+1) mod DEPTH, Pc_in <= Pc_in + 4*WORDS (32-bit wrap).
REQ-019 SHALL hold word offset rw (clog2(WORDS) bits) and line pointer rp; Inst = slot[rp] word rw, combinational.
REQ-020 Empty = (Line_cnt==0); Full = (Line_cnt==DEPTH); Inst is don't-care while Empty.
REQ-021 On Rd_en && !Empty && !Jmp_branch_valid: Pc_out <= Pc_out+4; rw <= rw+1; if rw==WORDS-1 then rw<=0, rp<=(rp+1) mod DEPTH, line retired.
REQ-022 Rd_en while Empty SHALL be ignored (no pointer, Pc_out or count change).
REQ-023 Line_cnt: +1 on write, -1 on retire, unchanged when both occur in the same cycle.
REQ-024 No bypass: a written line is visible at Inst the cycle after its write (Empty deasserts one cycle after Dout_valid).
REQ-025 On Jmp_branch_valid (highest priority, overrides write and read same cycle): Line_cnt<=0, wp<=0, rp<=0, rw<=target[clog2(WORDS)+1:2], Pc_in<=target with low clog2(WORDS)+2 bits cleared, Pc_out<=target with bits[1:0] cleared.
REQ-026 After redirect, the first line written SHALL present the word at the target offset first; words below the offset are skipped.
REQ-027 Rd_en_cache SHALL deassert combinationally when Full and reassert in the cycle Line_cnt drops below DEPTH.

Reset
REQ-028 On reset: Pc_in=0, Pc_out=0, wp=rp=rw=0, Line_cnt=0, Empty=1, Full=0, Rd_en_cache=1.
REQ-029 Reset SHALL override redirect, write and read in the same cycle; slot contents need not be cleared.
REQ-030 Reset asserted mid-stream SHALL discard all queued lines; no queued word appears at Inst after reset.

Structure
REQ-031 Package ifq_pkg SHALL hold XLEN=32, default WORDS/DEPTH, and derived widths (offset, pointer, count).
REQ-032 Line storage SHALL be sub-module ifq_line_ram: DEPTH x (32*WORDS), one sync write port, one async read port.
REQ-033 Pointer/count/PC logic SHALL reside in ifq_param.

Verification
REQ-034 Reset, then lines 0x..00-03 at Dout_valid -> Empty=0 next cycle, Inst=word0, Pc_out=0, Pc_in=0x10.
REQ-035 Four Rd_en on one line -> Pc_out 0,4,8,0xC, Line_cnt 1->0 after the fourth read, Empty=1.
REQ-036 Four writes without reads -> Full=1, Rd_en_cache=0, fifth Dout_valid ignored, Pc_in=0x40.
REQ-037 Jmp_branch_valid with target 0x1008 while Full -> Line_cnt=0, Pc_in=0x1000, Pc_out=0x1008; next line -> Inst=word2.
REQ-038 Write and last-word retire in the same cycle at Line_cnt=2 -> Line_cnt stays 2; wp/rp wrap from 3 to 0.
REQ-039 Redirect, Dout_valid and Rd_en in the same cycle -> only the redirect takes effect; Empty=1 next cycle.
